usb_rx_block_assembler: RTL and testbench

Downstream consumer of the USB receive top level. It takes the byte stream (`rx_data`/`write_enable`/`eop`/`rcv_error`) of two consecutive DATA0 packets, strips PID and CRC16 bytes, and assembles a 640-bit block header plus 256-bit difficulty target. It presents them to the hash core under a valid/ack handshake and flags malformed sequences.

---
 rtl/usb_rx_pkg.sv | 20 ++
 rtl/usb_rx_block_assembler_if.sv | 31 +++
 rtl/usb_crc_skid.sv | 43 ++++
 rtl/usb_rx_block_assembler.sv | 124 ++++++++++++
 tb/tb_usb_rx_block_assembler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
// Shared definitions for the USB receive block assembler slice: the DATA0
// PID value, the assembler state encoding, and the header/target widths.
package usb_rx_pkg;

   localparam logic [7:0]  DATA0_PID = 8'hC3;
   localparam int unsigned HEADER_W  = 640;
   localparam int unsigned DIFF_W    = 256;
   localparam int unsigned ASM_W     = HEADER_W + DIFF_W;
   localparam int unsigned CNT_W     = 7;

   typedef enum logic [2:0] {
      WAIT_PID1,
      DATA1,
      WAIT_PID2,
      DATA2,
      HOLD
   } state_e;

endpackage

// File: rtl/usb_rx_block_assembler_if.sv
// usb_rx_block_assembler_if
// Bundles the byte stream from the USB receiver together with the block
// handshake toward the hash core.
//   master : upstream/hash-core side (drives stream and block_ack)
//   slave  : the assembler (drives header, difficulty, block_valid,
//            block_error, overrun)
interface usb_rx_block_assembler_if;
   import usb_rx_pkg::*;

   logic [7:0]          rx_data;
   logic                write_enable;
   logic                eop;
   logic                rcv_error;
   logic                block_ack;
   logic [HEADER_W-1:0] header;
   logic [DIFF_W-1:0]   difficulty;
   logic                block_valid;
   logic                block_error;
   logic                overrun;

   modport master (
      output rx_data, write_enable, eop, rcv_error, block_ack,
      input  header, difficulty, block_valid, block_error, overrun
   );

   modport slave (
      input  rx_data, write_enable, eop, rcv_error, block_ack,
      output header, difficulty, block_valid, block_error, overrun
   );

endinterface

// File: rtl/usb_crc_skid.sv
// usb_crc_skid
// Two-byte delay line. A byte leaves the skid (commit_o/commit_byte_o) only
// once two newer bytes have arrived behind it, so the last two bytes of a
// packet -- the CRC16 -- are still inside when eop arrives and get dropped
// by clr_i.
//   clk, rst       : clock, synchronous active-high reset
//   clr_i          : empty the skid (eop or abort)
//   push_i, din_i  : incoming byte strobe and data
//   commit_o       : strobe, oldest byte is being pushed out this cycle
//   commit_byte_o  : the byte being pushed out
module usb_crc_skid (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       push_i,
   input  logic [7:0] din_i,
   output logic       commit_o,
   output logic [7:0] commit_byte_o
);

   logic [7:0] s0_q, s1_q;
   logic       v0_q, v1_q;

   // Commit is reported even when clr_i is set in the same cycle: a byte
   // arriving together with eop is processed before the eop discard.
   assign commit_o      = push_i & v1_q;
   assign commit_byte_o = s1_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         s0_q <= '0;
         s1_q <= '0;
         v0_q <= 1'b0;
         v1_q <= 1'b0;
      end else if (push_i) begin
         s1_q <= s0_q;
         s0_q <= din_i;
         v1_q <= v0_q;
         v0_q <= 1'b1;
      end
   end

endmodule

// File: rtl/usb_rx_block_assembler.sv
// usb_rx_block_assembler
// Collects two DATA0 packets from the USB receive stream, strips PID and
// CRC16, and builds a 640-bit block header plus 256-bit difficulty target
// that is held for the hash core under a valid/ack handshake.
//   clk, rst : clock, synchronous active-high reset
//   rx_if    : slave side of usb_rx_block_assembler_if
//              in : rx_data, write_enable, eop, rcv_error, block_ack
//              out: header, difficulty, block_valid, block_error, overrun
module usb_rx_block_assembler #(
   parameter logic [7:0]  DATA0_PID  = usb_rx_pkg::DATA0_PID,
   parameter int unsigned PKT1_BYTES = 64,
   parameter int unsigned PKT2_BYTES = 48
) (
   input logic                     clk,
   input logic                     rst,
   usb_rx_block_assembler_if.slave rx_if
);
   import usb_rx_pkg::*;

   // The commit counter runs across both packets, so packet 2 finishes at
   // the combined byte count.
   localparam logic [CNT_W-1:0] LIM1 = CNT_W'(PKT1_BYTES);
   localparam logic [CNT_W-1:0] LIM2 = CNT_W'(PKT1_BYTES + PKT2_BYTES);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, limit;
   logic [ASM_W-1:0]   asm_q;
   logic               ovr_q, ovr_d;
   logic               err_q, valid_q;
   logic               abort, do_commit, skid_push, skid_commit;
   logic [7:0]         skid_byte;

   usb_crc_skid u_skid (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (abort | rx_if.eop),
      .push_i        (skid_push),
      .din_i         (rx_if.rx_data),
      .commit_o      (skid_commit),
      .commit_byte_o (skid_byte)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovr_d     = ovr_q;
      abort     = 1'b0;
      do_commit = 1'b0;
      skid_push = 1'b0;
      limit     = (state_q == DATA2) ? LIM2 : LIM1;

      unique case (state_q)
         WAIT_PID1, WAIT_PID2: begin
            if (rx_if.write_enable) begin
               if (rx_if.rx_data == DATA0_PID)
                  state_d = (state_q == WAIT_PID1) ? DATA1 : DATA2;
               else
                  abort = 1'b1;
            end
            if (rx_if.eop) abort = 1'b1;
         end
         DATA1, DATA2: begin
            skid_push = rx_if.write_enable;
            if (skid_commit) begin
               if (cnt_q == limit) begin
                  abort = 1'b1;
               end else begin
                  do_commit = 1'b1;
                  cnt_d     = cnt_q + 1'b1;
               end
            end
            // cnt_d already includes a commit caused by a byte in this cycle.
            if (rx_if.eop && !abort) begin
               if (cnt_d == limit)
                  state_d = (state_q == DATA1) ? WAIT_PID2 : HOLD;
               else
                  abort = 1'b1;
            end
         end
         HOLD: begin
            if (rx_if.write_enable) ovr_d = 1'b1;
            if (rx_if.block_ack) begin
               state_d = WAIT_PID1;
               ovr_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         default: state_d = WAIT_PID1;
      endcase

      if (rx_if.rcv_error && state_q != HOLD) abort = 1'b1;

      if (abort) begin
         state_d   = WAIT_PID1;
         cnt_d     = '0;
         do_commit = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_PID1;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         err_q   <= abort;
         valid_q <= (state_d == HOLD);
         if (do_commit) asm_q <= {asm_q[ASM_W-9:0], skid_byte};
      end
   end

   assign rx_if.header      = asm_q[ASM_W-1:DIFF_W];
   assign rx_if.difficulty  = asm_q[DIFF_W-1:0];
   assign rx_if.block_valid = valid_q;
   assign rx_if.block_error = err_q;
   assign rx_if.overrun     = ovr_q;

endmodule

// File: tb/tb_usb_rx_block_assembler.sv
// tb_usb_rx_block_assembler
// Table of short control vectors, directed multi-packet sequences, and a
// randomized run, all checked cycle by cycle against a packet-level model
// built from byte queues.
module tb_usb_rx_block_assembler;

   localparam logic [7:0] PID = 8'hC3;
   localparam int P1 = 64;
   localparam int P2 = 48;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   usb_rx_block_assembler_if bus ();

   usb_rx_block_assembler #(
      .DATA0_PID  (PID),
      .PKT1_BYTES (P1),
      .PKT2_BYTES (P2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rx_if (bus)
   );

   int vectors    = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   int           m_phase;   // 0 want PID1, 1 in pkt1, 2 want PID2, 3 in pkt2, 4 holding
   logic [7:0]   m_q[$];    // bytes of the packet in progress (payload + CRC)
   logic [7:0]   m_acc[$];  // payload accepted from finished packets
   bit           m_ov;
   bit           m_err;
   logic [895:0] m_exp;

   logic [7:0] pay [112];
   bit         gaps;

   task automatic model_step(input bit r, we, input logic [7:0] d, input bit e, re, ak);
      bit ab = 1'b0;
      int lim, pend, committed;
      m_err = 1'b0;
      if (r) begin
         m_phase = 0; m_q.delete(); m_acc.delete(); m_ov = 1'b0;
         return;
      end
      if (m_phase == 4) begin
         if (we) m_ov = 1'b1;
         if (ak) begin m_phase = 0; m_ov = 1'b0; m_acc.delete(); end
         return;
      end
      if (re) ab = 1'b1;
      else if (m_phase == 0 || m_phase == 2) begin
         if (we) begin
            if (d == PID) begin m_phase++; m_q.delete(); end
            else ab = 1'b1;
         end
         if (e) ab = 1'b1;
      end else begin
         if (we) m_q.push_back(d);
         lim       = (m_phase == 1) ? P1 : P1 + P2;
         pend      = (m_q.size() > 2) ? int'(m_q.size()) - 2 : 0;
         committed = int'(m_acc.size()) + pend;
         if (committed > lim) ab = 1'b1;
         else if (e) begin
            if (committed == lim) begin
               for (int i = 0; i < pend; i++) m_acc.push_back(m_q[i]);
               m_q.delete();
               if (m_phase == 1) m_phase = 2;
               else begin
                  m_phase = 4;
                  m_exp = '0;
                  foreach (m_acc[i]) m_exp = {m_exp[887:0], m_acc[i]};
               end
            end else ab = 1'b1;
         end
      end
      if (ab) begin
         m_err = 1'b1; m_phase = 0; m_q.delete(); m_acc.delete();
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk1(input string n, input logic a, input logic e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
      end
   endtask

   task automatic chkw(input string n, input logic [639:0] a, input logic [639:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   // One clock: drive inputs, take the edge, then compare against the model.
   task automatic cyc(input bit r, we, input logic [7:0] d, input bit e, re, ak);
      rst              = r;
      bus.write_enable = we;
      bus.rx_data      = d;
      bus.eop          = e;
      bus.rcv_error    = re;
      bus.block_ack    = ak;
      @(posedge clk);
      #1;
      model_step(r, we, d, e, re, ak);
      chk1("block_valid", bus.block_valid, m_phase == 4);
      chk1("block_error", bus.block_error, m_err);
      chk1("overrun", bus.overrun, m_ov);
      if (r) begin
         chkw("header_rst", bus.header, '0);
         chkw("difficulty_rst", {384'b0, bus.difficulty}, '0);
      end else if (m_phase == 4) begin
         chkw("header", bus.header, m_exp[895:256]);
         chkw("difficulty", {384'b0, bus.difficulty}, {384'b0, m_exp[255:0]});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit e);
      if (gaps) idle($urandom_range(0, 2));
      cyc(0, 1, b, e, 0, 0);
   endtask

   task automatic send_pkt(input logic [7:0] pid, input int first, input int n,
                           input logic [7:0] c0, c1, input bit eop_last);
      send_byte(pid, 0);
      for (int i = 0; i < n; i++) send_byte(pay[(first + i) % 112], 0);
      send_byte(c0, 0);
      send_byte(c1, eop_last);
      if (!eop_last) cyc(0, 0, 8'h00, 1, 0, 0);
   endtask

   task automatic send_pair(input bit eop_last);
      send_pkt(PID, 0, P1, 8'h66, 8'h9D, eop_last);
      send_pkt(PID, P1, P2, 8'h06, 8'h93, eop_last);
   endtask

   // ---------------- control vector table ----------------
   typedef struct {
      bit         r, we;
      logic [7:0] d;
      bit         e, re, ak;
      bit         ev, ee, eo;
   } vec_t;

   vec_t tbl [14];

   logic [639:0] exp_hdr;
   logic [255:0] exp_dif;

   initial begin
      rst = 1'b1;
      bus.write_enable = 1'b0; bus.rx_data = '0; bus.eop = 1'b0;
      bus.rcv_error = 1'b0; bus.block_ack = 1'b0;
      gaps = 1'b0;
      m_phase = 0; m_ov = 1'b0; m_err = 1'b0; m_exp = '0;

      tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 0};  // reset
      tbl[1]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0};  // idle
      tbl[2]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 0};  // ack while not valid
      tbl[3]  = '{0, 1, 8'h4B, 0, 0, 0, 0, 1, 0};  // bad PID
      tbl[4]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0};  // error is one cycle
      tbl[5]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0};  // eop while waiting PID
      tbl[6]  = '{0, 1, 8'hC3, 0, 0, 0, 0, 0, 0};  // good PID
      tbl[7]  = '{0, 1, 8'h11, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 8'h22, 0, 1, 0, 0, 1, 0};  // rcv_error with a byte
      tbl[9]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{0, 1, 8'hC3, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0};  // empty packet
      tbl[12] = '{0, 1, 8'hC3, 1, 0, 0, 0, 1, 0};  // PID and eop together
      tbl[13] = '{0, 0, 8'h00, 0, 1, 0, 0, 1, 0};  // rcv_error while idle

      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].r, tbl[i].we, tbl[i].d, tbl[i].e, tbl[i].re, tbl[i].ak);
         chk1($sformatf("tbl%0d_valid", i), bus.block_valid, tbl[i].ev);
         chk1($sformatf("tbl%0d_error", i), bus.block_error, tbl[i].ee);
         chk1($sformatf("tbl%0d_overrun", i), bus.overrun, tbl[i].eo);
      end
      idle(2);

      // ---- nominal block ----
      for (int i = 0; i < 112; i++) pay[i] = 8'((i * 37 + 11) & 8'hFF);
      pay[0] = 8'h01; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;
      pay[4] = 8'h50; pay[5] = 8'h12;
      pay[64] = 8'h42; pay[65] = 8'h47; pay[66] = 8'he9; pay[67] = 8'hf3;
      pay[76] = 8'h0f; pay[77] = 8'h2b; pay[78] = 8'h57; pay[79] = 8'h10;
      for (int i = 80; i < 112; i++) pay[i] = 8'h00;
      pay[85] = 8'h04; pay[86] = 8'h86; pay[87] = 8'h4c;
      exp_hdr = '0;
      for (int i = 0; i < 80; i++) exp_hdr = {exp_hdr[631:0], pay[i]};
      exp_dif = '0;
      for (int i = 80; i < 112; i++) exp_dif = {exp_dif[247:0], pay[i]};

      send_pair(1'b0);
      chk1("nom_valid", bus.block_valid, 1'b1);
      chkw("nom_header", bus.header, exp_hdr);
      chkw("nom_difficulty", {384'b0, bus.difficulty}, {384'b0, exp_dif});
      cyc(0, 1, 8'hAA, 0, 0, 0);                 // overrun in HOLD
      chk1("ovr_set", bus.overrun, 1'b1);
      chkw("ovr_header_kept", bus.header, exp_hdr);
      cyc(0, 0, 8'h00, 0, 1, 0);                 // rcv_error ignored in HOLD
      chk1("hold_rcverr_valid", bus.block_valid, 1'b1);
      cyc(0, 0, 8'h00, 0, 0, 1);                 // ack
      chk1("ack_valid", bus.block_valid, 1'b0);
      chk1("ack_overrun", bus.overrun, 1'b0);
      idle(2);

      // ---- bad PID then good pair ----
      cyc(0, 1, 8'h4B, 0, 0, 0);
      chk1("badpid_err", bus.block_error, 1'b1);
      idle(1);
      chk1("badpid_err_low", bus.block_error, 1'b0);
      send_pair(1'b1);
      chk1("badpid_then_valid", bus.block_valid, 1'b1);
      chkw("badpid_then_header", bus.header, exp_hdr);
      cyc(0, 0, 8'h00, 0, 0, 1);

      // ---- short packet 1 (63 bytes) ----
      send_pkt(PID, 0, 63, 8'h66, 8'h9D, 1'b0);
      chk1("short_err", bus.block_error, 1'b1);
      idle(2);

      // ---- long packet 1 (65 bytes): abort on the 65th commit ----
      send_byte(PID, 0);
      for (int i = 0; i < 65; i++) send_byte(pay[i], 0);
      send_byte(8'h66, 0);
      chk1("long_no_err_yet", bus.block_error, 1'b0);
      send_byte(8'h9D, 0);
      chk1("long_err", bus.block_error, 1'b1);
      cyc(0, 0, 8'h00, 1, 0, 0);                 // eop now lands in WAIT_PID1
      idle(2);

      // ---- rcv_error at byte 30 of packet 2 ----
      send_pkt(PID, 0, P1, 8'h66, 8'h9D, 1'b0);
      send_byte(PID, 0);
      for (int i = 0; i < 29; i++) send_byte(pay[P1 + i], 0);
      cyc(0, 1, pay[P1 + 29], 0, 1, 0);
      chk1("rcverr_err", bus.block_error, 1'b1);
      idle(1);
      send_pair(1'b0);
      chk1("rcverr_then_valid", bus.block_valid, 1'b1);
      chkw("rcverr_then_header", bus.header, exp_hdr);
      cyc(0, 0, 8'h00, 0, 0, 1);

      // ---- reset mid packet 1 ----
      send_byte(PID, 0);
      for (int i = 0; i < 20; i++) send_byte(pay[i], 0);
      cyc(1, 0, 8'h00, 0, 0, 0);
      idle(1);
      chk1("rst_no_err", bus.block_error, 1'b0);
      send_pair(1'b0);
      chk1("rst_then_valid", bus.block_valid, 1'b1);
      chkw("rst_then_header", bus.header, exp_hdr);
      cyc(0, 0, 8'h00, 0, 0, 1);
      idle(2);

      // ---- randomized transactions ----
      gaps = 1'b1;
      for (int t = 0; t < 40; t++) begin
         int kind;
         logic [7:0] bp;
         for (int i = 0; i < 112; i++) pay[i] = 8'($urandom_range(0, 255));
         kind = $urandom_range(0, 7);
         case (kind)
            0: begin
               bp = 8'($urandom_range(0, 255));
               if (bp == PID) bp = bp ^ 8'h01;
               send_byte(bp, 0);
               send_pair($urandom_range(0, 1) == 1);
            end
            1: begin
               send_pkt(PID, 0, $urandom_range(0, 66), 8'h66, 8'h9D, $urandom_range(0, 1) == 1);
               send_pkt(PID, P1, P2, 8'h06, 8'h93, 1'b0);
            end
            2: begin
               send_pkt(PID, 0, P1, 8'h66, 8'h9D, 1'b0);
               send_pkt(PID, P1, $urandom_range(44, 52), 8'h06, 8'h93, $urandom_range(0, 1) == 1);
            end
            3: begin
               send_pkt(PID, 0, P1, 8'h66, 8'h9D, 1'b1);
               send_byte(PID, 0);
               for (int i = 0; i < int'($urandom_range(0, 47)); i++) send_byte(pay[P1 + i], 0);
               cyc(0, $urandom_range(0, 1) == 1, 8'h5A, 0, 1, 0);
            end
            default: send_pair($urandom_range(0, 1) == 1);
         endcase
         idle($urandom_range(0, 3));
         if (m_phase == 4) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) cyc(0, 1, 8'hAA, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) cyc(0, 0, 8'h00, 0, 1, 0);
            idle($urandom_range(0, 2));
            cyc(0, 0, 8'h00, 0, 0, 1);
         end
         idle($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard limit so the run always terminates.
   initial begin
      #2000000;
      miscompares++;
      $display("FAIL timeout: got no end of test, want end before time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "time limit reached");
   end

endmodule
